// File: rtl/bus_arbiter_rr.sv
// Three-group bus arbiter: fixed priority P1 > P2 > P3 with age-based promotion
// of starved P2/P3, round-robin within each group, and a pickup timeout on grants.
module bus_arbiter_rr #(
  parameter int unsigned PICKUP_TIMEOUT = 8,
  parameter int unsigned AGE_LIMIT      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] m_reqs,
  input  logic [11:0] m_blocked,
  input  logic        bus_free,
  output logic [11:0] m_grants,
  output logic [3:0]  mid_current,
  output logic [2:0]  state,
  output logic        timeout_pulse
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_WAIT_FREE = 3'd2,
    S_GRANT     = 3'd3,
    S_OWNED     = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_mid, w_mid_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            r_first, w_first_nxt;
  logic            r_tmo, w_tmo_nxt;
  logic [2:0][1:0] r_ptr, w_ptr_nxt;
  logic [3:0]      r_age2, w_age2_nxt;
  logic [3:0]      r_age3, w_age3_nxt;

  logic [11:0] w_eff;
  logic [2:0]  w_any;
  logic        w_aged2, w_aged3;
  logic [1:0]  w_grp;
  logic [3:0]  w_grp_req;
  logic [1:0]  w_ptr_sel;
  logic [1:0]  w_cand, w_idx;
  logic        w_found;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign w_eff   = m_reqs & ~m_blocked;
  assign w_any   = {|w_eff[11:8], |w_eff[7:4], |w_eff[3:0]};
  assign w_aged2 = w_any[1] && (r_age2 >= 4'(AGE_LIMIT));
  assign w_aged3 = w_any[2] && (r_age3 >= 4'(AGE_LIMIT));

  // Aged groups pre-empt fixed priority; P3 beats P2 when both are aged.
  always_comb begin
    w_grp = 2'd2;
    if (w_aged3)       w_grp = 2'd2;
    else if (w_aged2)  w_grp = 2'd1;
    else if (w_any[0]) w_grp = 2'd0;
    else if (w_any[1]) w_grp = 2'd1;
    else               w_grp = 2'd2;
  end

  always_comb begin
    w_grp_req = w_eff[11:8];
    w_ptr_sel = r_ptr[2];
    case (w_grp)
      2'd0: begin
        w_grp_req = w_eff[3:0];
        w_ptr_sel = r_ptr[0];
      end
      2'd1: begin
        w_grp_req = w_eff[7:4];
        w_ptr_sel = r_ptr[1];
      end
      default: begin
        w_grp_req = w_eff[11:8];
        w_ptr_sel = r_ptr[2];
      end
    endcase
  end

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_cand = w_ptr_sel + 2'(k);
      if (!w_found && w_grp_req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mid_nxt   = r_mid;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = 1'b0;
    w_tmo_nxt   = 1'b0;
    w_ptr_nxt   = r_ptr;
    w_age2_nxt  = r_age2;
    w_age3_nxt  = r_age3;
    case (r_state)
      S_IDLE: begin
        if (|w_eff) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        if (!(|w_eff)) begin
          w_state_nxt = S_IDLE;
          w_mid_nxt   = '1;
        end else begin
          w_mid_nxt   = {w_grp, w_idx};
          w_age2_nxt  = (w_grp == 2'd1) ? '0 : (w_any[1] ? sat_inc(r_age2) : r_age2);
          w_age3_nxt  = (w_grp == 2'd2) ? '0 : (w_any[2] ? sat_inc(r_age3) : r_age3);
          w_state_nxt = S_WAIT_FREE;
        end
      end
      S_WAIT_FREE: begin
        if (bus_free) begin
          w_state_nxt = S_GRANT;
          w_cnt_nxt   = '0;
        end
      end
      S_GRANT: begin
        // Pickup and timeout both move the pointer past the granted master.
        if (!bus_free || (r_cnt == 4'(PICKUP_TIMEOUT - 1))) begin
          case (r_mid[3:2])
            2'd0:    w_ptr_nxt[0] = r_mid[1:0];
            2'd1:    w_ptr_nxt[1] = r_mid[1:0];
            default: w_ptr_nxt[2] = r_mid[1:0];
          endcase
        end
        if (!bus_free) begin
          w_state_nxt = S_OWNED;
          w_first_nxt = 1'b1;
        end else if (r_cnt == 4'(PICKUP_TIMEOUT - 1)) begin
          w_state_nxt = S_IDLE;
          w_tmo_nxt   = 1'b1;
          w_mid_nxt   = '1;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_OWNED: begin
        if (bus_free) begin
          w_state_nxt = S_IDLE;
          w_mid_nxt   = '1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_mid_nxt   = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mid   <= '1;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_tmo   <= 1'b0;
      r_ptr   <= '1;
      r_age2  <= '0;
      r_age3  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mid   <= w_mid_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
      r_tmo   <= w_tmo_nxt;
      r_ptr   <= w_ptr_nxt;
      r_age2  <= w_age2_nxt;
      r_age3  <= w_age3_nxt;
    end
  end

  assign m_grants      = ((r_state == S_GRANT) || ((r_state == S_OWNED) && r_first))
                         ? (12'd1 << r_mid) : '0;
  assign mid_current   = r_mid;
  assign state         = r_state;
  assign timeout_pulse = r_tmo;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed scenarios plus a randomized
// bus-master population compared cycle by cycle against a transaction-level model.
module tb_bus_arbiter_rr;

  localparam int PT    = 8;
  localparam int AL    = 4;
  localparam int BOUND = (AL + 1) * 4;
  localparam int IDLE = 0, ARB = 1, WAITF = 2, GRANT = 3, OWNED = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] m_reqs;
  logic [11:0] m_blocked;
  logic        bus_free;
  logic [11:0] m_grants;
  logic [3:0]  mid_current;
  logic [2:0]  state;
  logic        timeout_pulse;

  bus_arbiter_rr #(.PICKUP_TIMEOUT(PT), .AGE_LIMIT(AL)) dut (
    .clk(clk), .rst(rst), .m_reqs(m_reqs), .m_blocked(m_blocked), .bus_free(bus_free),
    .m_grants(m_grants), .mid_current(mid_current), .state(state), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: arbitration phase, owner, grant-cycle count, pointers, ages.
  int          md_ph, md_owner, md_gcnt;
  bit          md_first, md_tmo;
  int          md_ptr[3];
  int          md_age[3];
  logic [11:0] md_arb_eff;
  int          wt[12];
  logic [11:0] prev_g;

  function automatic bit grp_any(input logic [11:0] e, input int g);
    return |e[g*4 +: 4];
  endfunction

  task automatic md_pick(input logic [11:0] e, output int win);
    int order[$];
    order = {};
    if (md_age[2] >= AL && grp_any(e, 2)) order.push_back(2);
    if (md_age[1] >= AL && grp_any(e, 1)) order.push_back(1);
    order.push_back(0);
    order.push_back(1);
    order.push_back(2);
    win = -1;
    foreach (order[n]) begin
      if (win < 0 && grp_any(e, order[n])) begin
        for (int off = 1; off <= 4; off++) begin
          if (win < 0 && e[order[n]*4 + (md_ptr[order[n]] + off) % 4])
            win = order[n]*4 + (md_ptr[order[n]] + off) % 4;
        end
      end
    end
  endtask

  task automatic md_step(input bit rs, input logic [11:0] rq, input logic [11:0] bk, input logic bf);
    logic [11:0] e;
    int w;
    e = rq & ~bk;
    md_tmo = 1'b0;
    if (rs) begin
      md_ph = IDLE; md_owner = 15; md_gcnt = 0; md_first = 1'b0;
      md_ptr = '{3, 3, 3}; md_age = '{0, 0, 0}; md_arb_eff = '0;
    end else begin
      case (md_ph)
        IDLE: if (e != 0) md_ph = ARB;
        ARB: begin
          if (e == 0) begin
            md_ph = IDLE; md_owner = 15;
          end else begin
            md_pick(e, w);
            md_arb_eff = e;
            md_owner = w;
            for (int g = 1; g <= 2; g++) begin
              if (g == w / 4) md_age[g] = 0;
              else if (grp_any(e, g)) md_age[g] = (md_age[g] < 15) ? md_age[g] + 1 : 15;
            end
            md_ph = WAITF;
          end
        end
        WAITF: if (bf) begin md_ph = GRANT; md_gcnt = 0; end
        GRANT: begin
          if (!bf) begin
            md_ph = OWNED; md_first = 1'b1;
            md_ptr[md_owner / 4] = md_owner % 4;
          end else if (md_gcnt + 1 >= PT) begin
            md_tmo = 1'b1;
            md_ptr[md_owner / 4] = md_owner % 4;
            md_owner = 15; md_ph = IDLE;
          end else begin
            md_gcnt++;
          end
        end
        OWNED: begin
          md_first = 1'b0;
          if (bf) begin md_owner = 15; md_ph = IDLE; end
        end
        default: md_ph = IDLE;
      endcase
    end
  endtask

  function automatic logic [11:0] md_grants();
    if (md_ph == GRANT || (md_ph == OWNED && md_first)) return 12'd1 << md_owner;
    return 12'd0;
  endfunction

  task automatic tick(input bit rs, input logic [11:0] rq, input logic [11:0] bk, input logic bf);
    int w;
    int mx;
    rst = rs; m_reqs = rq; m_blocked = bk; bus_free = bf;
    @(posedge clk);
    md_step(rs, rq, bk, bf);
    #1;
    check_eq("grants", m_grants, md_grants());
    check_eq("mid", mid_current, md_owner);
    check_eq("state", state, md_ph);
    check_eq("tmo", timeout_pulse, md_tmo);
    check_eq("onehot", $onehot0(m_grants), 1);
    if (rs) begin
      foreach (wt[i]) wt[i] = 0;
    end else if (m_grants != 0 && prev_g == 0) begin
      w = -1; mx = 0;
      for (int i = 0; i < 12; i++) if (m_grants[i]) w = i;
      for (int i = 0; i < 12; i++) begin
        if (i == w) wt[i] = 0;
        else if (md_arb_eff[i]) wt[i]++;
        else wt[i] = 0;
        if (wt[i] > mx) mx = wt[i];
      end
      check_eq("starve", mx <= BOUND, 1);
    end
    prev_g = m_grants;
  endtask

  task automatic do_reset();
    tick(1'b1, '0, '0, 1'b1);
    tick(1'b1, '0, '0, 1'b1);
  endtask

  task automatic to_grant(input logic [11:0] rq, input logic [11:0] bk, output logic [11:0] g);
    for (int n = 0; n < 8 && md_ph != GRANT; n++) tick(1'b0, rq, bk, 1'b1);
    g = m_grants;
  endtask

  task automatic serve(input logic [11:0] rq, input logic [11:0] bk, output logic [11:0] g);
    to_grant(rq, bk, g);
    tick(1'b0, rq, bk, 1'b0);
    tick(1'b0, rq, bk, 1'b1);
  endtask

  logic [11:0] g;
  logic [11:0] exp_order[6];
  logic [11:0] rq;
  int          cd[12];
  int          pick_dly;
  int          own_left;
  logic        bf;
  bit          rs;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; m_reqs = '0; m_blocked = '0; bus_free = 1'b1; prev_g = '0;
    foreach (wt[i]) wt[i] = 0;

    // Reset values and first round-robin grant / rotation
    do_reset();
    check_eq("rst_mid", mid_current, 4'hF);
    check_eq("rst_grant", m_grants, 12'h000);
    check_eq("rst_state", state, 3'd0);
    check_eq("rst_tmo", timeout_pulse, 1'b0);
    tick(1'b0, 12'h003, '0, 1'b1);
    tick(1'b0, 12'h003, '0, 1'b1);
    tick(1'b0, 12'h003, '0, 1'b1);
    check_eq("rr_first", m_grants, 12'h001);
    tick(1'b0, 12'h003, '0, 1'b0);
    check_eq("owned_hold", m_grants, 12'h001);
    tick(1'b0, 12'h003, '0, 1'b0);
    check_eq("owned_clear", m_grants, 12'h000);
    check_eq("owned_mid", mid_current, 4'h0);
    tick(1'b0, 12'h003, '0, 1'b1);
    check_eq("release_mid", mid_current, 4'hF);
    to_grant(12'h003, '0, g);
    check_eq("rr_second", g, 12'h002);
    tick(1'b0, 12'h003, '0, 1'b0);
    tick(1'b0, 12'h001, '0, 1'b1);

    // Aging: P3 then P2 promoted over a permanently requesting P1
    do_reset();
    exp_order = '{12'h001, 12'h001, 12'h001, 12'h001, 12'h100, 12'h010};
    for (int k = 0; k < 6; k++) begin
      serve(12'h111, '0, g);
      check_eq($sformatf("age_order%0d", k), g, exp_order[k]);
    end

    // Blocked master is never granted
    do_reset();
    for (int k = 0; k < 3; k++) begin
      serve(12'h011, 12'h001, g);
      check_eq($sformatf("blocked%0d", k), g, 12'h010);
    end

    // Pickup timeout; request/block changes on the grantee do not cut the grant short
    do_reset();
    to_grant(12'h00C, '0, g);
    check_eq("tmo_grant", g, 12'h004);
    for (int k = 0; k < 7; k++) tick(1'b0, (k % 2 == 0) ? 12'h008 : 12'h00C, (k % 3 == 0) ? 12'h004 : 12'h000, 1'b1);
    check_eq("tmo_last_cycle", m_grants, 12'h004);
    tick(1'b0, 12'h00C, '0, 1'b1);
    check_eq("tmo_clear", m_grants, 12'h000);
    check_eq("tmo_pulse", timeout_pulse, 1'b1);
    check_eq("tmo_mid", mid_current, 4'hF);
    tick(1'b0, 12'h00C, '0, 1'b1);
    check_eq("tmo_pulse_end", timeout_pulse, 1'b0);
    to_grant(12'h00C, '0, g);
    check_eq("tmo_next", g, 12'h008);
    tick(1'b0, 12'h00C, '0, 1'b0);
    tick(1'b0, 12'h004, '0, 1'b1);

    // Reset during ownership
    do_reset();
    to_grant(12'h001, '0, g);
    tick(1'b0, 12'h001, '0, 1'b0);
    tick(1'b1, 12'h001, '0, 1'b0);
    check_eq("own_rst_state", state, 3'd0);
    check_eq("own_rst_grant", m_grants, 12'h000);
    check_eq("own_rst_mid", mid_current, 4'hF);
    tick(1'b0, '0, '0, 1'b1);
    to_grant(12'h00F, '0, g);
    check_eq("post_rst_m0", g, 12'h001);

    // Randomized masters: pickup delays up to and past the timeout, variable hold
    do_reset();
    rq = '0;
    foreach (cd[i]) cd[i] = $urandom_range(0, 3);
    bf = 1'b1; pick_dly = 0; own_left = 0;
    for (int c = 0; c < 10000; c++) begin
      rs = ($urandom_range(0, 999) == 0);
      for (int m = 0; m < 12; m++) begin
        if (!rq[m]) begin
          if (cd[m] == 0) rq[m] = 1'b1;
          else cd[m]--;
        end
      end
      tick(rs, rq, '0, bf);
      if (md_ph == OWNED && md_first) begin
        rq[md_owner] = 1'b0;
        cd[md_owner] = $urandom_range(0, 3);
        own_left = $urandom_range(0, 3);
      end
      case (md_ph)
        GRANT: begin
          if (md_gcnt == 0) pick_dly = $urandom_range(0, PT);
          bf = (md_gcnt < pick_dly);
        end
        OWNED: begin
          if (own_left == 0) bf = 1'b1;
          else begin
            bf = 1'b0;
            own_left--;
          end
        end
        default: bf = ($urandom_range(0, 3) != 0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
